// File: rtl/mips_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// default reset vector, next-PC select encoding and small address helpers.
package mips_pkg;

    // Fetch FSM states
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        ISSUE = 2'd2,
        HALT  = 2'd3
    } state_e;

    // Next-PC source select
    typedef enum logic [1:0] {
        NPC_SEQ = 2'd0,
        NPC_BR  = 2'd1,
        NPC_J   = 2'd2,
        NPC_JR  = 2'd3
    } npc_sel_e;

    // Default first fetch address
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

    // Sign-extended, word-scaled branch displacement
    function automatic logic [31:0] br_offset(input logic [15:0] imm);
        br_offset = {{14{imm[15]}}, imm, 2'b00};
    endfunction

    // True when an address is not word aligned
    function automatic logic addr_misaligned(input logic [31:0] addr);
        addr_misaligned = (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/ifu_fetch_npc.sv
// Combinational next-PC selection for the fetch unit. Priority is
// register jump, then absolute jump, then taken branch, then sequential.
module npc
    import mips_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_i,
    input  logic        branch_i,
    input  logic        br_taken_i,
    input  logic        jump_i,
    input  logic        jreg_i,
    input  logic [31:0] rs_data_i,
    output logic [31:0] npc_o,
    output logic        misalign_o
);

    npc_sel_e    sel_s;
    logic [31:0] pc_plus4_s;
    logic        unused_opcode_s;

    assign pc_plus4_s = pc_i + 32'd4;

    // Opcode field is decoded elsewhere; only the immediate/target fields matter here
    assign unused_opcode_s = ^instr_i[31:26];

    // Select the next-PC source with jreg taking precedence over jump
    always_comb begin
        sel_s = NPC_SEQ;
        if (jreg_i) begin
            sel_s = NPC_JR;
        end else if (jump_i) begin
            sel_s = NPC_J;
        end else if (branch_i && br_taken_i) begin
            sel_s = NPC_BR;
        end else begin
            sel_s = NPC_SEQ;
        end
    end

    // Form the next PC; all arithmetic wraps modulo 2^32
    always_comb begin
        npc_o = pc_plus4_s;
        case (sel_s)
            NPC_JR:  npc_o = rs_data_i;
            NPC_J:   npc_o = {pc_plus4_s[31:28], instr_i[25:0], 2'b00};
            NPC_BR:  npc_o = pc_plus4_s + br_offset(instr_i[15:0]);
            NPC_SEQ: npc_o = pc_plus4_s;
            default: npc_o = pc_plus4_s;
        endcase
        misalign_o = addr_misaligned(npc_o);
    end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: issues memory reads, captures the instruction,
// holds it for the datapath and advances the PC on completion. Memory
// timeouts and misaligned targets park the unit in HALT with err set.
module ifu_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = RESET_PC_DEF,
    parameter int unsigned IMEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        exe_done,
    input  logic        branch,
    input  logic        br_taken,
    input  logic        jump,
    input  logic        jreg,
    input  logic [31:0] rs_data,
    output logic        err
);

    localparam int unsigned TO_EFF = (IMEM_TIMEOUT < 1) ? 1 : IMEM_TIMEOUT;
    localparam int          CNT_W  = $clog2(TO_EFF + 1);

    state_e             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        instr_q, instr_d;
    logic [CNT_W-1:0]   wcnt_q, wcnt_d;
    logic               err_q, err_d;

    logic [31:0]        npc_s;
    logic               misalign_s;

    npc u_npc (
        .pc_i       (pc_q),
        .instr_i    (instr_q),
        .branch_i   (branch),
        .br_taken_i (br_taken),
        .jump_i     (jump),
        .jreg_i     (jreg),
        .rs_data_i  (rs_data),
        .npc_o      (npc_s),
        .misalign_o (misalign_s)
    );

    // Next-state logic for FSM, PC, instruction latch, wait counter and fault flag
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        wcnt_d  = wcnt_q;
        err_d   = err_q;
        case (state_q)
            FETCH: begin
                wcnt_d = {CNT_W{1'b0}};
                if (imem_ready) begin
                    // Zero-latency memory: accept data in the request cycle
                    instr_d = imem_rdata;
                    state_d = ISSUE;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (imem_ready) begin
                    instr_d = imem_rdata;
                    wcnt_d  = {CNT_W{1'b0}};
                    state_d = ISSUE;
                end else begin
                    wcnt_d = wcnt_q + CNT_W'(1);
                    if (wcnt_d == CNT_W'(TO_EFF)) begin
                        state_d = HALT;
                        err_d   = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            ISSUE: begin
                if (exe_done) begin
                    if (misalign_s) begin
                        // Misaligned target: keep pc so the faulting instruction is visible
                        state_d = HALT;
                        err_d   = 1'b1;
                    end else begin
                        pc_d    = npc_s;
                        state_d = FETCH;
                    end
                end else begin
                    state_d = ISSUE;
                end
            end
            HALT: begin
                state_d = HALT;
                err_d   = 1'b1;
            end
            default: begin
                state_d = HALT;
                err_d   = 1'b1;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0000_0000;
            wcnt_q  <= {CNT_W{1'b0}};
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
        end
    end

    // Request and valid are state decodes, forced low while reset is held
    always_comb begin
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        if (rst) begin
            imem_req    = 1'b0;
            instr_valid = 1'b0;
        end else begin
            imem_req    = (state_q == FETCH) || (state_q == WAIT);
            instr_valid = (state_q == ISSUE);
        end
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign pc_plus4  = pc_q + 32'd4;
    assign instr     = instr_q;
    assign err       = err_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed testbench for ifu_fetch: reset, sequential run, branches,
// jumps, misalign fault, memory latency/timeout, reset in WAIT, PC wrap.
module tb_ifu_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        exe_done;
    logic        branch;
    logic        br_taken;
    logic        jump;
    logic        jreg;
    logic [31:0] rs_data;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ifu_fetch #(.RESET_PC(32'h0000_3000), .IMEM_TIMEOUT(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .exe_done    (exe_done),
        .branch      (branch),
        .br_taken    (br_taken),
        .jump        (jump),
        .jreg        (jreg),
        .rs_data     (rs_data),
        .err         (err)
    );

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // From a FETCH cycle: return rdata immediately, then complete it with the given controls
    task automatic run_instr(input logic [31:0] rdata, input logic br, input logic bt,
                             input logic j, input logic jr, input logic [31:0] rs);
        imem_ready = 1'b1;
        imem_rdata = rdata;
        step();
        imem_ready = 1'b0;
        branch     = br;
        br_taken   = bt;
        jump       = j;
        jreg       = jr;
        rs_data    = rs;
        exe_done   = 1'b1;
        step();
        exe_done   = 1'b0;
        branch     = 1'b0;
        br_taken   = 1'b0;
        jump       = 1'b0;
        jreg       = 1'b0;
        rs_data    = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", imem_req); end
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        step();
        n_checks++; if (pc !== 32'h0000_3000) begin n_fail++; $display("FAIL reset_pc: got %h want 00003000", pc); end
        n_checks++; if (instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", instr); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
        rst = 1'b0;
        #1;
        n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL post_reset_req: got %b want 1", imem_req); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc;
        logic [31:0] word;
        for (int i = 0; i < 3; i++) begin
            exp_pc = 32'h0000_3000 + 32'(4 * i);
            word   = 32'h0000_0020 + 32'(i);
            n_checks++; if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin n_fail++; $display("FAIL seq_fetch%0d: got req=%b addr=%h want 1 %h", i, imem_req, imem_addr, exp_pc); end
            n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL seq_novalid%0d: got %b want 0", i, instr_valid); end
            imem_ready = 1'b1;
            imem_rdata = word;
            step();
            imem_ready = 1'b0;
            n_checks++; if (instr_valid !== 1'b1 || instr !== word) begin n_fail++; $display("FAIL seq_issue%0d: got v=%b instr=%h want 1 %h", i, instr_valid, instr, word); end
            n_checks++; if (pc !== exp_pc || pc_plus4 !== exp_pc + 32'd4) begin n_fail++; $display("FAIL seq_pc%0d: got %h/%h want %h/%h", i, pc, pc_plus4, exp_pc, exp_pc + 32'd4); end
            exe_done = 1'b1;
            step();
            exe_done = 1'b0;
        end
    endtask

    task automatic test_branch();
        run_instr(32'h0000_0020, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        n_checks++; if (pc !== 32'h0000_3010) begin n_fail++; $display("FAIL br_setup: got %h want 00003010", pc); end
        run_instr(32'h1000_FFFE, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        n_checks++; if (pc !== 32'h0000_300C || imem_addr !== 32'h0000_300C) begin n_fail++; $display("FAIL br_taken: got %h want 0000300c", pc); end
        run_instr(32'h0000_0020, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        run_instr(32'h1000_FFFE, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        n_checks++; if (pc !== 32'h0000_3014) begin n_fail++; $display("FAIL br_not_taken: got %h want 00003014", pc); end
    endtask

    task automatic test_jump();
        run_instr(32'h0000_0008, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_3020);
        n_checks++; if (pc !== 32'h0000_3020) begin n_fail++; $display("FAIL jr_basic: got %h want 00003020", pc); end
        run_instr(32'h0800_0C40, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        n_checks++; if (pc !== 32'h0000_3100) begin n_fail++; $display("FAIL j_target: got %h want 00003100", pc); end
        run_instr(32'h0000_0008, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_3020);
        run_instr(32'h0800_0C40, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_3400);
        n_checks++; if (pc !== 32'h0000_3400) begin n_fail++; $display("FAIL jr_over_j: got %h want 00003400", pc); end
    endtask

    task automatic test_fault();
        run_instr(32'h0000_0008, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_3020);
        run_instr(32'h0000_0008, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_3402);
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL fault_err: got %b want 1", err); end
        n_checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL fault_outputs: got req=%b v=%b want 0 0", imem_req, instr_valid); end
        n_checks++; if (pc !== 32'h0000_3020) begin n_fail++; $display("FAIL fault_pc: got %h want 00003020", pc); end
        imem_ready = 1'b1;
        exe_done   = 1'b1;
        for (int i = 0; i < 3; i++) step();
        imem_ready = 1'b0;
        exe_done   = 1'b0;
        n_checks++; if (err !== 1'b1 || imem_req !== 1'b0 || pc !== 32'h0000_3020) begin n_fail++; $display("FAIL halt_sticky: got err=%b req=%b pc=%h want 1 0 00003020", err, imem_req, pc); end
        rst = 1'b1;
        step();
        n_checks++; if (err !== 1'b0 || pc !== 32'h0000_3000) begin n_fail++; $display("FAIL fault_clear: got err=%b pc=%h want 0 00003000", err, pc); end
        rst = 1'b0;
        #1;
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_3000) begin n_fail++; $display("FAIL fault_restart: got req=%b addr=%h want 1 00003000", imem_req, imem_addr); end
    endtask

    task automatic test_latency();
        int cnt = 0;
        exe_done   = 1'b1;
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (imem_req === 1'b1) cnt++;
            step();
        end
        exe_done   = 1'b0;
        imem_ready = 1'b1;
        imem_rdata = 32'hA5A5_0F0F;
        if (imem_req === 1'b1) cnt++;
        step();
        imem_ready = 1'b0;
        n_checks++; if (cnt != 4) begin n_fail++; $display("FAIL lat_req_cycles: got %0d want 4", cnt); end
        n_checks++; if (instr_valid !== 1'b1 || instr !== 32'hA5A5_0F0F) begin n_fail++; $display("FAIL lat_capture: got v=%b instr=%h want 1 a5a50f0f", instr_valid, instr); end
        n_checks++; if (pc !== 32'h0000_3000) begin n_fail++; $display("FAIL lat_exe_ignored: got %h want 00003000", pc); end
        exe_done = 1'b1;
        step();
        exe_done = 1'b0;
        n_checks++; if (imem_addr !== 32'h0000_3004) begin n_fail++; $display("FAIL lat_next: got %h want 00003004", imem_addr); end
    endtask

    task automatic test_timeout();
        imem_ready = 1'b0;
        for (int i = 0; i < 16; i++) step();
        n_checks++; if (imem_req !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL to_before: got req=%b err=%b want 1 0", imem_req, err); end
        step();
        n_checks++; if (imem_req !== 1'b0 || err !== 1'b1) begin n_fail++; $display("FAIL to_halt: got req=%b err=%b want 0 1", imem_req, err); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        n_checks++; if (err !== 1'b0 || imem_addr !== 32'h0000_3000) begin n_fail++; $display("FAIL to_clear: got err=%b addr=%h want 0 00003000", err, imem_addr); end
    endtask

    task automatic test_reset_mid_wait();
        imem_ready = 1'b0;
        step();
        imem_ready = 1'b1;
        imem_rdata = 32'h1234_5678;
        rst        = 1'b1;
        step();
        n_checks++; if (instr !== 32'h0 || pc !== 32'h0000_3000) begin n_fail++; $display("FAIL rmw_state: got instr=%h pc=%h want 0 00003000", instr, pc); end
        n_checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL rmw_outputs: got req=%b v=%b want 0 0", imem_req, instr_valid); end
        rst = 1'b0;
        #1;
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_3000) begin n_fail++; $display("FAIL rmw_refetch: got req=%b addr=%h want 1 00003000", imem_req, imem_addr); end
        step();
        imem_ready = 1'b0;
        n_checks++; if (instr_valid !== 1'b1 || instr !== 32'h1234_5678) begin n_fail++; $display("FAIL rmw_late_ready: got v=%b instr=%h want 1 12345678", instr_valid, instr); end
        exe_done = 1'b1;
        step();
        exe_done = 1'b0;
    endtask

    task automatic test_wrap();
        run_instr(32'h0000_0008, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        n_checks++; if (pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL wrap_plus4: got %h/%h want fffffffc/00000000", pc, pc_plus4); end
        run_instr(32'h0000_0020, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        n_checks++; if (pc !== 32'h0 || imem_addr !== 32'h0 || err !== 1'b0) begin n_fail++; $display("FAIL wrap_seq: got pc=%h err=%b want 00000000 0", pc, err); end
    endtask

    initial begin
        rst        = 1'b1;
        imem_ready = 1'b0;
        imem_rdata = 32'h0;
        exe_done   = 1'b0;
        branch     = 1'b0;
        br_taken   = 1'b0;
        jump       = 1'b0;
        jreg       = 1'b0;
        rs_data    = 32'h0;
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_fault();
        test_latency();
        test_timeout();
        test_reset_mid_wait();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 The block SHALL have one clock and one reset; reset is synchronous and active-high: clk input 1 (rising-edge clock), rst input 1 (sync active-high reset).
REQ-002 Parameter RESET_PC, default 32'h0000_3000, is the first fetch address.
REQ-003 Parameter IMEM_TIMEOUT, default 16, is the maximum number of WAIT cycles before an error.
REQ-004 imem_req output 1: instruction-memory read request.
REQ-005 imem_addr output 32: byte address of the fetch, equal to pc.
REQ-006 imem_ready input 1: imem_rdata is valid this cycle.
REQ-007 imem_rdata input 32: fetched instruction word.
REQ-008 instr output 32: registered instruction presented to the decoder.
REQ-009 instr_valid output 1: instr is held stable for execution.
REQ-010 pc output 32: address of the current instr.
REQ-011 pc_plus4 output 32: pc+4, used as the jal/jalr link value.
REQ-012 exe_done input 1: the datapath has completed instr and the next-PC inputs are valid.
REQ-013 branch input 1: decoder Branch flag for instr.
REQ-014 br_taken input 1: branch condition result from the datapath.
REQ-015 jump input 1: decoder Jump flag (j/jal).
REQ-016 jreg input 1: the instruction is jr/jalr.
REQ-017 rs_data input 32: register target for jr/jalr.
REQ-018 err output 1: sticky fetch fault.

Function
REQ-019 The FSM SHALL have four states: FETCH, WAIT, ISSUE, HALT.
REQ-020 FETCH: assert imem_req=1 with imem_addr=pc and go to WAIT.
REQ-021 WAIT: keep imem_req=1. On imem_ready=1, capture instr<=imem_rdata and go to ISSUE. Otherwise increment the wait counter; when the counter reaches IMEM_TIMEOUT, go to HALT.
REQ-022 A response in the same cycle as the request SHALL be accepted. Data arriving on imem_ready in FETCH is captured and the block goes directly to ISSUE.
REQ-023 ISSUE: instr_valid=1 and instr/pc are held stable. On exe_done=1, load pc<=npc and go to FETCH. Otherwise stay in ISSUE.
REQ-024 npc priority: jreg -> rs_data; else jump -> {pc_plus4[31:28], instr[25:0], 2'b00}; else branch&br_taken -> pc_plus4 + (sign_extend(instr[15:0])<<2); else pc_plus4.
REQ-025 All address arithmetic SHALL be 32-bit modulo 2^32, so 32'hFFFF_FFFC+4 wraps to 0.
REQ-026 An npc with npc[1:0]!=0 SHALL be a fault: pc is not updated, the FSM goes to HALT, and err<=1.
REQ-027 HALT: imem_req=0, instr_valid=0, err=1, all inputs ignored; the state is left only by rst.
REQ-028 exe_done outside ISSUE SHALL be ignored. imem_ready outside FETCH/WAIT SHALL be ignored.
REQ-029 Simultaneous jreg and jump SHALL resolve as jreg.
REQ-030 branch=1 with br_taken=0 SHALL yield pc_plus4.
REQ-031 pc_plus4 SHALL be combinational from pc.
REQ-032 Minimum throughput SHALL be one instruction per 2 cycles (zero-latency memory plus exe_done in the first ISSUE cycle).

Reset
REQ-033 While rst=1 at a clock edge: state<=FETCH, pc<=RESET_PC, instr<=32'h0, wait counter<=0, err<=0.
REQ-034 During and after reset, outputs SHALL be imem_req=0 and instr_valid=0 until the first post-reset FETCH cycle.
REQ-035 rst SHALL override all other inputs in any state, including mid-WAIT with a pending response and HALT. A late imem_ready after reset is treated per REQ-022.

Structure
REQ-036 The shared package mips_pkg SHALL hold: the state enum (FETCH/WAIT/ISSUE/HALT), the RESET_PC default, and the npc-select encoding (SEQ/BR/J/JR).
REQ-037 Next-PC computation SHALL be one combinational sub-module, npc, taking pc, instr, branch, br_taken, jump, jreg, rs_data and producing npc and a misalign flag.
REQ-038 The FSM, pc register, instr register and wait counter SHALL live in ifu_fetch.

Verification
REQ-039 Reset then sequential run: rst for 2 cycles, imem_ready=1 every request, exe_done=1 in every ISSUE cycle -> imem_addr 0x3000, 0x3004, 0x3008 on successive FETCH cycles, instr_valid every 2nd cycle.
REQ-040 Branch: pc=0x3010, instr=0x1000FFFE (beq, offset -2), branch=1, br_taken=1 -> next pc 0x300C. Same stimulus with br_taken=0 -> next pc 0x3014.
REQ-041 Jumps: pc=0x3020, instr=0x08000C40, jump=1 -> next pc 0x00003100. jreg=1 and jump=1 together with rs_data=0x3400 -> next pc 0x3400.
REQ-042 Fault: jreg=1 with rs_data=0x3402 -> err=1 next cycle, imem_req=0 thereafter, pc stays 0x3020; rst clears it.
REQ-043 Latency and timeout: imem_ready delayed 3 cycles -> imem_req held high 4 cycles and instr is captured correctly. imem_ready never asserted -> HALT after 16 WAIT cycles.
REQ-044 Reset mid-WAIT: rst=1 in a WAIT cycle with imem_ready=1 -> instr stays 0, pc=0x3000, and the next FETCH reissues address 0x3000.
